// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_responder
// Purpose  : Memory-mapped I/O responder on the processor data-memory bus.
//            Decodes a 32-byte window, drives PortOut, synchronises PortIn
//            and latches its change events, and provides a compare timer
//            with an interrupt request.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            MemWrite, MemRead   - store / load strobes from the MEM stage
//            Address, WriteData  - byte address (bits [1:0] ignored), data
//            ReadData, Select    - combinational load data, window hit
//            PortIn              - asynchronous external input
//            PortOut, IRQ        - registered output port and interrupt
// Revision : 1.0 - initial release
// ============================================================================
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0020,
   parameter int          PORT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [31:0]           Address,
   input  logic [31:0]           WriteData,
   output logic [31:0]           ReadData,
   output logic                  Select,
   input  logic [PORT_WIDTH-1:0] PortIn,
   output logic [PORT_WIDTH-1:0] PortOut,
   output logic                  IRQ
);

   localparam logic [2:0] c_off_out    = 3'd0;
   localparam logic [2:0] c_off_in     = 3'd1;
   localparam logic [2:0] c_off_status = 3'd2;
   localparam logic [2:0] c_off_cmp    = 3'd3;
   localparam logic [2:0] c_off_cnt    = 3'd4;
   localparam logic [2:0] c_off_ctrl   = 3'd5;

   logic [PORT_WIDTH-1:0] out_q, out_d;
   logic [PORT_WIDTH-1:0] s1_q, s1_d;
   logic [PORT_WIDTH-1:0] s2_q, s2_d;
   logic [PORT_WIDTH-1:0] p_q, p_d;
   logic [1:0]            status_q, status_d;   // [0] IN_CHG, [1] TMR_EXP
   logic [31:0]           cmp_q, cmp_d;
   logic [31:0]           cnt_q, cnt_d;
   logic [3:0]            ctrl_q, ctrl_d;       // [0] EN [1] AUTO [2] IE_CHG [3] IE_TMR
   logic                  irq_q, irq_d;

   logic [2:0]            w_off;
   logic                  w_wr;
   logic                  w_chg;
   logic                  w_tmr_evt;
   logic                  w_unused_addr;

   assign Select        = (Address[31:5] == BASE_ADDR[31:5]);
   assign w_off         = Address[4:2];
   assign w_wr          = MemWrite && Select;
   assign w_unused_addr = &{1'b0, Address[1:0]};

   // One-cycle pulse: p trails s2 by one edge, so they differ only once per change.
   assign w_chg     = (s2_q != p_q);
   assign w_tmr_evt = ctrl_q[0] && (cnt_q == cmp_q);

   assign PortOut = out_q;
   assign IRQ     = irq_q;

   // Read path works from current register state, so a combined
   // read/write returns the pre-write value.
   always_comb begin
      ReadData = 32'h0;
      if (MemRead && Select) begin
         case (w_off)
            c_off_out:    ReadData[PORT_WIDTH-1:0] = out_q;
            c_off_in:     ReadData[PORT_WIDTH-1:0] = s2_q;
            c_off_status: ReadData[1:0]            = status_q;
            c_off_cmp:    ReadData                 = cmp_q;
            c_off_cnt:    ReadData                 = cnt_q;
            c_off_ctrl:   ReadData[3:0]            = ctrl_q;
            default:      ReadData                 = 32'h0;
         endcase
      end
   end

   always_comb begin
      s1_d     = PortIn;
      s2_d     = s1_q;
      p_d      = s2_q;
      out_d    = out_q;
      cmp_d    = cmp_q;
      cnt_d    = cnt_q;
      ctrl_d   = ctrl_q;
      status_d = status_q;

      // Timer: expire takes priority over increment.
      if (w_tmr_evt) begin
         if (ctrl_q[1]) begin
            cnt_d = 32'h0;
         end else begin
            ctrl_d[0] = 1'b0;
         end
      end else if (ctrl_q[0]) begin
         cnt_d = cnt_q + 32'd1;
      end

      // Bus writes are applied last so they override timer side effects.
      if (w_wr) begin
         case (w_off)
            c_off_out:    out_d    = WriteData[PORT_WIDTH-1:0];
            c_off_status: status_d = status_q & ~WriteData[1:0];
            c_off_cmp:    cmp_d    = WriteData;
            c_off_cnt:    cnt_d    = WriteData;
            c_off_ctrl:   ctrl_d   = WriteData[3:0];
            default:      ;
         endcase
      end

      // Set events are OR-ed after the W1C so a same-cycle event wins.
      status_d = status_d | {w_tmr_evt, w_chg};

      irq_d = (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q    <= '0;
         s1_q     <= '0;
         s2_q     <= '0;
         p_q      <= '0;
         status_q <= 2'b00;
         cmp_q    <= 32'h0;
         cnt_q    <= 32'h0;
         ctrl_q   <= 4'h0;
         irq_q    <= 1'b0;
      end else begin
         out_q    <= out_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         p_q      <= p_d;
         status_q <= status_d;
         cmp_q    <= cmp_d;
         cnt_q    <= cnt_d;
         ctrl_q   <= ctrl_d;
         irq_q    <= irq_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_port_responder
// Purpose  : Directed scoreboard bench for mmio_port_responder. The stimulus
//            process queues an expected value with every read or observation;
//            a monitor on the falling edge pops and compares whenever the DUT
//            presents load data (MemRead && Select) or an observation is due.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_port_responder;

   localparam logic [31:0] B = 32'h1001_0020;

   localparam int K_RD   = 0;
   localparam int K_PORT = 1;
   localparam int K_IRQ  = 2;
   localparam int K_SEL  = 3;
   localparam int K_RDAT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Select;
   logic [7:0]  PortIn;
   logic [7:0]  PortOut;
   logic        IRQ;

   logic        obs_valid;
   int          obs_kind;

   logic [31:0] q_val[$];
   int          q_kind[$];
   string       q_name[$];

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] seq_ar[8];

   mmio_port_responder #(
      .BASE_ADDR (B),
      .PORT_WIDTH(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .MemWrite (MemWrite),
      .MemRead  (MemRead),
      .Address  (Address),
      .WriteData(WriteData),
      .ReadData (ReadData),
      .Select   (Select),
      .PortIn   (PortIn),
      .PortOut  (PortOut),
      .IRQ      (IRQ)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------- monitor
   always @(negedge clk) begin
      logic [31:0] act;
      logic [31:0] exp_v;
      int          k;
      string       nm;
      if ((MemRead && Select) || obs_valid) begin
         if (q_val.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_output: got ReadData=%h with no expected entry", ReadData);
         end else begin
            exp_v = q_val.pop_front();
            k     = q_kind.pop_front();
            nm    = q_name.pop_front();
            case (k)
               K_PORT:  act = {24'h0, PortOut};
               K_IRQ:   act = {31'h0, IRQ};
               K_SEL:   act = {31'h0, Select};
               default: act = ReadData;
            endcase
            n_vec++;
            if (act !== exp_v) begin
               n_miss++;
               $display("FAIL %s: got %h expected %h", nm, act, exp_v);
            end
         end
      end
   end

   // ---------------------------------------------------------------- driver
   task automatic push(input int k, input logic [31:0] v, input string nm);
      q_val.push_back(v);
      q_kind.push_back(k);
      q_name.push_back(nm);
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      @(posedge clk);
      #1;
      reset     = 1'b0;
      MemWrite  = w;
      MemRead   = r;
      Address   = a;
      WriteData = d;
      obs_valid = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] off, input logic [31:0] d);
      drive(1'b1, 1'b0, B + off, d);
   endtask

   task automatic rd(input logic [31:0] off, input logic [31:0] e, input string nm);
      drive(1'b0, 1'b1, B + off, 32'h0);
      push(K_RD, e, nm);
   endtask

   task automatic rw(input logic [31:0] off, input logic [31:0] d, input logic [31:0] e, input string nm);
      drive(1'b1, 1'b1, B + off, d);
      push(K_RD, e, nm);
   endtask

   task automatic obs(input int k, input logic [31:0] a, input logic [31:0] e, input string nm);
      drive(1'b0, 1'b0, a, 32'h0);
      obs_valid = 1'b1;
      obs_kind  = k;
      push(k, e, nm);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      reset     = 1'b1;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
      PortIn    = 8'h00;
      obs_valid = 1'b0;
      obs_kind  = 0;
      repeat (3) @(posedge clk);

      // Reset state
      rd(32'h00, 32'h0, "rst_out");
      rd(32'h04, 32'h0, "rst_in");
      rd(32'h08, 32'h0, "rst_status");
      rd(32'h0C, 32'h0, "rst_cmp");
      rd(32'h10, 32'h0, "rst_cnt");
      rd(32'h14, 32'h0, "rst_ctrl");
      rd(32'h18, 32'h0, "rst_rsvd18");
      rd(32'h1C, 32'h0, "rst_rsvd1c");
      obs(K_PORT, 32'h1001_0000, 32'h0, "rst_portout");
      obs(K_IRQ,  32'h1001_0000, 32'h0, "rst_irq");
      obs(K_SEL,  32'h1001_0000, 32'h0, "sel_below");
      obs(K_SEL,  32'h1001_0040, 32'h0, "sel_above");
      obs(K_SEL,  B + 32'h1C,    32'h1, "sel_top");
      obs(K_RDAT, B,             32'h0, "rdata_noread");

      // OUT register and PortOut
      wr(32'h00, 32'h0000_01A5);
      obs(K_PORT, 32'h0, 32'hA5, "portout_a5");
      rd(32'h00, 32'h0000_00A5, "out_rb");
      rw(32'h00, 32'h5A, 32'h0000_00A5, "out_rw_old");
      rd(32'h00, 32'h0000_005A, "out_rw_new");
      wr(32'h18, 32'hFFFF_FFFF);
      rd(32'h18, 32'h0, "rsvd18_wr");

      // PortIn synchroniser, IN_CHG, IRQ and W1C
      wr(32'h14, 32'h4);
      rd(32'h04, 32'h0, "in_t0");
      PortIn = 8'h3C;
      rd(32'h04, 32'h0, "in_t1");
      rd(32'h04, 32'h3C, "in_t2");
      rd(32'h08, 32'h1, "chg_set");
      obs(K_IRQ, 32'h0, 32'h1, "irq_chg");
      wr(32'h08, 32'h1);
      obs(K_IRQ, 32'h0, 32'h1, "irq_lag");
      obs(K_IRQ, 32'h0, 32'h0, "irq_clr");
      rd(32'h08, 32'h0, "chg_clr");

      // Auto-reload timer
      wr(32'h0C, 32'd5);
      wr(32'h10, 32'd0);
      wr(32'h14, 32'h3);
      seq_ar = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
      for (int i = 0; i < 8; i++) rd(32'h10, seq_ar[i], "cnt_reload");
      rd(32'h08, 32'h2, "tmr_exp");
      wr(32'h08, 32'h2);
      rd(32'h08, 32'h0, "tmr_clr");
      rd(32'h08, 32'h0, "tmr_pre_refire");
      rd(32'h08, 32'h2, "tmr_refire");
      wr(32'h14, 32'h0);
      wr(32'h08, 32'h3);

      // One-shot timer
      wr(32'h10, 32'd0);
      wr(32'h14, 32'h1);
      seq_ar = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd5, 32'd5};
      for (int i = 0; i < 8; i++) rd(32'h10, seq_ar[i], "cnt_oneshot");
      rd(32'h14, 32'h0, "ctrl_autoclr");
      rd(32'h08, 32'h2, "oneshot_exp");

      // W1C on the same edge as a change event: set wins
      rd(32'h04, 32'h3C, "in_pre");
      PortIn = 8'h81;
      rd(32'h04, 32'h3C, "in_mid");
      wr(32'h08, 32'h3);
      rd(32'h08, 32'h1, "set_wins");
      rd(32'h04, 32'h81, "in_new");

      // Wrap-around
      idle();
      PortIn = 8'h00;
      wr(32'h0C, 32'd1);
      wr(32'h10, 32'hFFFF_FFFE);
      wr(32'h08, 32'h3);
      wr(32'h14, 32'h1);
      seq_ar = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
      for (int i = 0; i < 5; i++) rd(32'h10, seq_ar[i], "cnt_wrap");
      rd(32'h14, 32'h0, "wrap_ctrl");
      rd(32'h08, 32'h2, "wrap_exp");

      // Reset mid-count with a concurrent CNT write
      wr(32'h0C, 32'd100);
      wr(32'h10, 32'd0);
      wr(32'h14, 32'hF);
      wr(32'h00, 32'h77);
      obs(K_PORT, 32'h0, 32'h77, "portout_77");
      drive(1'b1, 1'b0, B + 32'h10, 32'h1234);
      reset = 1'b1;
      rd(32'h10, 32'h0, "rst2_cnt");
      rd(32'h00, 32'h0, "rst2_out");
      rd(32'h04, 32'h0, "rst2_in");
      rd(32'h08, 32'h0, "rst2_status");
      rd(32'h0C, 32'h0, "rst2_cmp");
      rd(32'h14, 32'h0, "rst2_ctrl");
      obs(K_PORT, 32'h0, 32'h0, "rst2_portout");
      obs(K_IRQ,  32'h0, 32'h0, "rst2_irq");

      idle();
      idle();
      idle();
      while (q_val.size() > 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: got no response expected %h", q_name.pop_front(), q_val.pop_front());
         void'(q_kind.pop_front());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
